mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single-port synchronous RAM.
// One RAM access in flight at a time; ties are broken against the last grant.
module mem_arbiter (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [8:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [8:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_done,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        last_grant_r;
  logic        grant_r;
  logic        lat_we_r;
  logic        mem_we_r;
  logic        mem_re_r;

  logic        arb_valid_s;
  logic        arb_port_s;
  logic        take_s;
  logic        sel_we_s;
  logic [8:0]  sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        mem_we_d_s;
  logic        mem_re_d_s;
  logic        cpu_done_d_s;
  logic        dbg_done_d_s;
  logic        cap_cpu_s;
  logic        cap_dbg_s;

  // Arbitration: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    arb_valid_s = cpu_req | dbg_req;
    if (cpu_req && dbg_req) begin
      arb_port_s = ~last_grant_r;
    end else if (dbg_req) begin
      arb_port_s = 1'b1;
    end else begin
      arb_port_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (lat_we_r) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RDWAIT;
        end
      end
      RDWAIT:  next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs and capture strobes.
  always_comb begin
    take_s       = (state_r == IDLE) && arb_valid_s;
    sel_we_s     = arb_port_s ? dbg_we    : cpu_we;
    sel_addr_s   = arb_port_s ? dbg_addr  : cpu_addr;
    sel_wdata_s  = arb_port_s ? dbg_wdata : cpu_wdata;
    mem_we_d_s   = take_s & sel_we_s;
    mem_re_d_s   = take_s & ~sel_we_s;
    cpu_done_d_s = (next_state_s == DONE) && (state_r != DONE) && !grant_r;
    dbg_done_d_s = (next_state_s == DONE) && (state_r != DONE) && grant_r;
    cap_cpu_s    = (state_r == RDWAIT) && !grant_r;
    cap_dbg_s    = (state_r == RDWAIT) && grant_r;
  end

  // Transaction capture, RAM strobes, read data and done pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      lat_we_r     <= 1'b0;
      mem_addr     <= 9'h000;
      mem_wdata    <= 32'h0000_0000;
      mem_we_r     <= 1'b0;
      mem_re_r     <= 1'b0;
      cpu_rdata    <= 32'h0000_0000;
      dbg_rdata    <= 32'h0000_0000;
      cpu_done     <= 1'b0;
      dbg_done     <= 1'b0;
    end else begin
      if (take_s) begin
        last_grant_r <= arb_port_s;
        grant_r      <= arb_port_s;
        lat_we_r     <= sel_we_s;
        mem_addr     <= sel_addr_s;
        mem_wdata    <= sel_wdata_s;
      end
      mem_we_r <= mem_we_d_s;
      mem_re_r <= mem_re_d_s;
      if (cap_cpu_s) begin
        cpu_rdata <= mem_rdata;
      end
      if (cap_dbg_s) begin
        dbg_rdata <= mem_rdata;
      end
      cpu_done <= cpu_done_d_s;
      dbg_done <= dbg_done_d_s;
    end
  end

  // Reset in the ACCESS cycle must keep the RAM from committing the access.
  assign mem_we = mem_we_r & ~Reset;
  assign mem_re = mem_re_r & ~Reset;
  assign busy   = (state_r != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [8:0]  cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        cpu_done, dbg_done, mem_we, mem_re, busy;

  always #5 Clock = ~Clock;

  mem_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Bench RAM: data valid one cycle after mem_re.
  logic [31:0] ram [0:511];
  logic [31:0] ram_q;
  logic        ram_clr;
  assign mem_rdata = ram_q;

  always @(posedge Clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'h0;
      ram_q <= 32'h0;
    end else begin
      if (mem_re) ram_q <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  int total = 0;
  int bad   = 0;

  // Transaction-level reference model.
  logic [31:0] shadow [0:511];
  int          rem;
  bit          lg, gp, t_we;
  logic [8:0]  t_addr, e_addr;
  logic [31:0] t_wdata, e_wdata, e_crd, e_drd;
  bit          e_we, e_re, e_cd, e_dd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_step();
    if (Reset) begin
      rem = 0; lg = 1'b1; gp = 1'b0;
      e_addr = 9'h0; e_wdata = 32'h0; e_we = 1'b0; e_re = 1'b0;
      e_crd = 32'h0; e_drd = 32'h0; e_cd = 1'b0; e_dd = 1'b0;
    end else begin
      if (e_we) shadow[t_addr] = t_wdata;
      e_we = 1'b0;
      e_re = 1'b0;
      if (rem == 0) begin
        if (cpu_req || dbg_req) begin
          gp      = (cpu_req && dbg_req) ? !lg : dbg_req;
          lg      = gp;
          t_we    = gp ? dbg_we : cpu_we;
          t_addr  = gp ? dbg_addr : cpu_addr;
          t_wdata = gp ? dbg_wdata : cpu_wdata;
          e_addr  = t_addr;
          e_wdata = t_wdata;
          e_we    = t_we;
          e_re    = !t_we;
          rem     = t_we ? 2 : 3;
        end
      end else begin
        if (rem == 2 && !t_we) begin
          if (gp) e_drd = shadow[t_addr];
          else    e_crd = shadow[t_addr];
        end
        rem = rem - 1;
      end
      e_cd = (rem == 1) && !gp;
      e_dd = (rem == 1) && gp;
    end
  endtask

  task automatic check_all();
    chk("cpu_done", cpu_done, e_cd);
    chk("dbg_done", dbg_done, e_dd);
    chk("done_overlap", cpu_done & dbg_done, 32'h0);
    chk("busy", busy, rem != 0);
    chk("mem_we", mem_we, e_we & !Reset);
    chk("mem_re", mem_re, e_re & !Reset);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("dbg_rdata", dbg_rdata, e_drd);
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    check_all();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  // Issue one request from IDLE and return its latency in cycles (-1 on timeout).
  task automatic run_txn(input bit p, input bit we, input logic [8:0] a,
                         input logic [31:0] d, output int lat);
    int n;
    bit got;
    if (p) begin dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1; end
    else   begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
    n = 1;
    got = 1'b0;
    while (!got && n < 12) begin
      tick();
      n++;
      if (p ? dbg_done : cpu_done) got = 1'b1;
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    lat = got ? n : -1;
    if (!got) $display("FAIL txn_timeout: got no done expected done within 11 cycles");
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lat, tc, td, cyc, k;
    bit cpu_rearm, dbg_rearm;
    int order [4];

    Reset = 1'b1; ram_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 9'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 9'h0; dbg_wdata = 32'h0;
    for (int i = 0; i < 512; i++) shadow[i] = 32'h0;
    e_we = 1'b0;
    tick();
    ram_clr = 1'b0;
    tick();
    chk("reset_busy", busy, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_cpu_rdata", cpu_rdata, 32'h0);
    Reset = 1'b0;
    tick();

    vecs[0]  = '{1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0,        3};
    vecs[1]  = '{1'b0, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 4};
    vecs[2]  = '{1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h0,        3};
    vecs[3]  = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678, 4};
    vecs[4]  = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'h12345678, 4};
    vecs[5]  = '{1'b1, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 4};
    vecs[6]  = '{1'b0, 1'b1, 9'h000, 32'hA5A5A5A5, 32'h0,        3};
    vecs[7]  = '{1'b0, 1'b0, 9'h000, 32'h0,        32'hA5A5A5A5, 4};
    vecs[8]  = '{1'b1, 1'b1, 9'h001, 32'h11111111, 32'h0,        3};
    vecs[9]  = '{1'b1, 1'b1, 9'h002, 32'h22222222, 32'h0,        3};
    vecs[10] = '{1'b0, 1'b1, 9'h020, 32'hCAFEF00D, 32'h0,        3};
    vecs[11] = '{1'b1, 1'b0, 9'h005, 32'h0,        32'h0,        4};

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      chk("vec_latency", lat, vecs[i].exp_lat);
      if (!vecs[i].we) chk("vec_rdata", vecs[i].port ? dbg_rdata : cpu_rdata, vecs[i].exp_rd);
      tick();
    end

    // Simultaneous reads after reset: CPU first, debug done 4 cycles later.
    do_reset();
    cpu_we = 1'b0; cpu_addr = 9'h001; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 9'h002; dbg_req = 1'b1;
    cyc = 1; tc = -1; td = -1;
    while (td < 0 && cyc < 30) begin
      tick();
      cyc++;
      if (cpu_done) begin tc = cyc; cpu_req = 1'b0; end
      if (dbg_done) begin td = cyc; dbg_req = 1'b0; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("tie_cpu_latency", tc, 4);
    chk("tie_dbg_gap", td - tc, 4);
    chk("tie_cpu_rdata", cpu_rdata, 32'h11111111);
    chk("tie_dbg_rdata", dbg_rdata, 32'h22222222);
    tick();

    // Continuous contention: requests dropped in done, re-raised next cycle.
    do_reset();
    cpu_we = 1'b1; cpu_addr = 9'h040; cpu_wdata = 32'h0F0F0F0F; cpu_req = 1'b1;
    dbg_we = 1'b0; dbg_addr = 9'h040; dbg_req = 1'b1;
    k = 0; cyc = 0; cpu_rearm = 1'b0; dbg_rearm = 1'b0;
    while (k < 4 && cyc < 80) begin
      tick();
      cyc++;
      if (cpu_rearm) begin cpu_req = 1'b1; cpu_rearm = 1'b0; end
      if (dbg_rearm) begin dbg_req = 1'b1; dbg_rearm = 1'b0; end
      if (cpu_done && k < 4) begin order[k] = 0; k++; cpu_req = 1'b0; cpu_rearm = 1'b1; end
      if (dbg_done && k < 4) begin order[k] = 1; k++; dbg_req = 1'b0; dbg_rearm = 1'b1; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("contend_count", k, 4);
    for (int i = 0; i < k; i++) chk("contend_order", order[i], i % 2);
    tick();
    tick();

    // Reset during ACCESS of a debug write: aborted, RAM untouched.
    dbg_we = 1'b1; dbg_addr = 9'h020; dbg_wdata = 32'h0BADF00D; dbg_req = 1'b1;
    tick();
    chk("abort_access_we", mem_we, 32'h1);
    Reset = 1'b1; dbg_req = 1'b0;
    tick();
    chk("abort_we", mem_we, 32'h0);
    chk("abort_busy", busy, 32'h0);
    chk("abort_done", dbg_done, 32'h0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", dbg_done, 32'h0);
    end
    run_txn(1'b0, 1'b0, 9'h020, 32'h0, lat);
    chk("abort_lat", lat, 4);
    chk("abort_rdata", cpu_rdata, 32'hCAFEF00D);
    tick();

    // Inputs changed during ACCESS must not leak into the transaction.
    cpu_we = 1'b1; cpu_addr = 9'h030; cpu_wdata = 32'h13579BDF; cpu_req = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_addr = 9'h031; cpu_wdata = 32'hFFFFFFFF;
    chk("hold_addr", mem_addr, 32'h030);
    chk("hold_wdata", mem_wdata, 32'h13579BDF);
    chk("hold_we", mem_we, 32'h1);
    cyc = 2;
    while (!cpu_done && cyc < 12) begin
      tick();
      cyc++;
    end
    cpu_req = 1'b0;
    chk("hold_latency", cyc, 3);
    tick();
    run_txn(1'b0, 1'b0, 9'h030, 32'h0, lat);
    chk("hold_rd_030", cpu_rdata, 32'h13579BDF);
    tick();
    run_txn(1'b0, 1'b0, 9'h031, 32'h0, lat);
    chk("hold_rd_031", cpu_rdata, 32'h0);
    tick();

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int c = 0; c < 2000; c++) begin
      tick();
      Reset = ($urandom_range(0, 149) == 0);
      if (e_cd) begin
        cpu_req = 1'b0;
      end else if (!cpu_req) begin
        if ($urandom_range(0, 3) == 0) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = 9'($urandom_range(0, 15)); cpu_wdata = $urandom;
        end
      end else if (rem != 0 && gp == 1'b0) begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 9'($urandom_range(0, 15)); cpu_wdata = $urandom;
      end
      if (e_dd) begin
        dbg_req = 1'b0;
      end else if (!dbg_req) begin
        if ($urandom_range(0, 3) == 0) begin
          dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = 9'($urandom_range(0, 15)); dbg_wdata = $urandom;
        end
      end else if (rem != 0 && gp == 1'b1) begin
        dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 9'($urandom_range(0, 15)); dbg_wdata = $urandom;
      end
    end
    Reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
